// File: rtl/thread_scheduler_if.sv
// Fetch-side thread scheduler bundle: block/wake/halt event inputs and the
// registered issue selection seen by the fetch PC mux.
interface thread_scheduler_if #(
    parameter int N_THREADS = 8,
    parameter int TID_W     = 3,
    parameter int IDLE_W    = 16
);
    logic                 stall;
    logic                 block_valid;
    logic [TID_W-1:0]     block_tid;
    logic                 wake_valid;
    logic [TID_W-1:0]     wake_tid;
    logic                 halt_valid;
    logic [TID_W-1:0]     halt_tid;
    logic                 issue_valid;
    logic [TID_W-1:0]     issue_tid;
    logic [N_THREADS-1:0] ready_mask;
    logic [IDLE_W-1:0]    idle_count;

    modport master (
        output stall, block_valid, block_tid, wake_valid, wake_tid, halt_valid, halt_tid,
        input  issue_valid, issue_tid, ready_mask, idle_count
    );

    modport slave (
        input  stall, block_valid, block_tid, wake_valid, wake_tid, halt_valid, halt_tid,
        output issue_valid, issue_tid, ready_mask, idle_count
    );
endinterface

// File: rtl/thread_scheduler.sv
// Round-robin fetch thread selector: tracks READY/BLOCKED/HALTED per thread and
// issues one READY thread per cycle with registered outputs.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_READY    | thread may be fetched
//   ST_BLOCKED  | waiting on a miss or long-latency op; a wake returns it
//   ST_HALTED   | retired; stays here until reset
module thread_scheduler #(
    parameter int N_THREADS = 8,
    parameter int TID_W     = 3,
    parameter int IDLE_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    thread_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_BLOCKED = 2'd1,
        ST_HALTED  = 2'd2
    } thr_state_e;

    thr_state_e           thr_q [N_THREADS];
    thr_state_e           thr_d [N_THREADS];
    logic [N_THREADS-1:0] cand;
    logic [TID_W-1:0]     rr_q, rr_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [TID_W-1:0]     issue_tid_q, issue_tid_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [N_THREADS-1:0] ready_q;
    logic                 found;
    logic [TID_W-1:0]     pick;
    int                   idx;

    // Per-thread next state: halt beats block beats wake; HALTED is sticky.
    always_comb begin
        cand = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            thr_d[t] = thr_q[t];
            if (thr_q[t] != ST_HALTED) begin
                if (bus.halt_valid && bus.halt_tid == TID_W'(t)) begin
                    thr_d[t] = ST_HALTED;
                end else if (bus.block_valid && bus.block_tid == TID_W'(t)) begin
                    thr_d[t] = ST_BLOCKED;
                end else if (bus.wake_valid && bus.wake_tid == TID_W'(t)
                             && thr_q[t] == ST_BLOCKED) begin
                    thr_d[t] = ST_READY;
                end
            end
            cand[t] = (thr_d[t] == ST_READY);
        end
    end

    // Scan starts one past the last issued thread so every READY thread gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= N_THREADS; k++) begin
            idx = (int'(rr_q) + k) % N_THREADS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = TID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_d          = rr_q;
        issue_tid_d   = issue_tid_q;
        issue_valid_d = issue_valid_q;
        if (bus.stall) begin
            issue_valid_d = issue_valid_q && cand[issue_tid_q];
        end else if (found) begin
            issue_valid_d = 1'b1;
            issue_tid_d   = pick;
            rr_d          = pick;
        end else begin
            issue_valid_d = 1'b0;
        end
        idle_d = idle_q;
        if (!issue_valid_d && idle_q != '1) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < N_THREADS; t++) begin
                thr_q[t] <= ST_READY;
            end
            rr_q          <= TID_W'(N_THREADS - 1);
            issue_valid_q <= 1'b0;
            issue_tid_q   <= '0;
            idle_q        <= '0;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                thr_q[t] <= thr_d[t];
            end
            rr_q          <= rr_d;
            issue_valid_q <= issue_valid_d;
            issue_tid_q   <= issue_tid_d;
            idle_q        <= idle_d;
        end
    end

    always_comb begin
        for (int t = 0; t < N_THREADS; t++) begin
            ready_q[t] = (thr_q[t] == ST_READY);
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_tid   = issue_tid_q;
    assign bus.ready_mask  = ready_q;
    assign bus.idle_count  = idle_q;
endmodule

// File: tb/tb_thread_scheduler.sv
// Directed table-driven bench for thread_scheduler with hand-computed expectations
// plus hand-written stall and mid-run reset sequences.
module tb_thread_scheduler;
    logic clk;
    logic rst_n;

    thread_scheduler_if #(.N_THREADS(8), .TID_W(3), .IDLE_W(16)) bus ();

    thread_scheduler #(.N_THREADS(8), .TID_W(3), .IDLE_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        bv;
        logic [2:0]  bt;
        logic        wv;
        logic [2:0]  wt;
        logic        hv;
        logic [2:0]  ht;
        logic        ev;
        logic [2:0]  et;
        logic [7:0]  em;
        logic [15:0] ei;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input int r, input int s, input int bv, input int bt,
                                input int wv, input int wt, input int hv, input int ht,
                                input int ev, input int et, input int em, input int ei);
        vec_t x;
        x.rst_n = 1'(r);
        x.stall = 1'(s);
        x.bv    = 1'(bv);
        x.bt    = 3'(bt);
        x.wv    = 1'(wv);
        x.wt    = 3'(wt);
        x.hv    = 1'(hv);
        x.ht    = 3'(ht);
        x.ev    = 1'(ev);
        x.et    = 3'(et);
        x.em    = 8'(em);
        x.ei    = 16'(ei);
        return x;
    endfunction

    task automatic check(input string name, input int step, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    endtask

    // One clock edge with the given inputs, then compare all outputs.
    task automatic apply(input vec_t x, input int step);
        rst_n           = x.rst_n;
        bus.stall       = x.stall;
        bus.block_valid = x.bv;
        bus.block_tid   = x.bt;
        bus.wake_valid  = x.wv;
        bus.wake_tid    = x.wt;
        bus.halt_valid  = x.hv;
        bus.halt_tid    = x.ht;
        @(posedge clk);
        #1;
        check("issue_valid", step, 16'(bus.issue_valid), 16'(x.ev));
        if (x.ev) check("issue_tid", step, 16'(bus.issue_tid), 16'(x.et));
        check("ready_mask", step, 16'(bus.ready_mask), 16'(x.em));
        check("idle_count", step, bus.idle_count, x.ei);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.block_valid = 1'b0;
        bus.block_tid   = '0;
        bus.wake_valid  = 1'b0;
        bus.wake_tid    = '0;
        bus.halt_valid  = 1'b0;
        bus.halt_tid    = '0;
        @(negedge clk);

        //           r s  bv bt wv wt hv ht  ev et  mask   idle
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0, 'hFF, 0));
        // round robin from reset
        for (int i = 0; i < 9; i++) tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,i%8, 'hFF, 0));
        // block 2 while 1 is issued, wake it later
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,1, 'hFF, 0));
        tbl.push_back(mk(1,0, 1,2, 0,0, 0,0, 1,3, 'hFB, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,4, 'hFB, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,5, 'hFB, 0));
        tbl.push_back(mk(1,0, 0,0, 1,2, 0,0, 1,6, 'hFF, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,7, 'hFF, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,0, 'hFF, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,1, 'hFF, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,2, 'hFF, 0));
        // block every thread
        tbl.push_back(mk(1,0, 1,0, 0,0, 0,0, 1,3, 'hFE, 0));
        tbl.push_back(mk(1,0, 1,1, 0,0, 0,0, 1,4, 'hFC, 0));
        tbl.push_back(mk(1,0, 1,2, 0,0, 0,0, 1,5, 'hF8, 0));
        tbl.push_back(mk(1,0, 1,3, 0,0, 0,0, 1,6, 'hF0, 0));
        tbl.push_back(mk(1,0, 1,4, 0,0, 0,0, 1,7, 'hE0, 0));
        tbl.push_back(mk(1,0, 1,5, 0,0, 0,0, 1,6, 'hC0, 0));
        tbl.push_back(mk(1,0, 1,6, 0,0, 0,0, 1,7, 'h80, 0));
        tbl.push_back(mk(1,0, 1,7, 0,0, 0,0, 0,7, 'h00, 1));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,7, 'h00, 2));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,7, 'h00, 3));
        tbl.push_back(mk(1,0, 0,0, 1,5, 0,0, 1,5, 'h20, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,5, 'h20, 3));
        tbl.push_back(mk(1,0, 0,0, 1,0, 0,0, 1,0, 'h21, 3));
        tbl.push_back(mk(1,0, 0,0, 1,1, 0,0, 1,1, 'h23, 3));
        tbl.push_back(mk(1,0, 0,0, 1,2, 0,0, 1,2, 'h27, 3));
        tbl.push_back(mk(1,0, 0,0, 1,3, 0,0, 1,3, 'h2F, 3));
        tbl.push_back(mk(1,0, 0,0, 1,4, 0,0, 1,4, 'h3F, 3));
        tbl.push_back(mk(1,0, 0,0, 1,6, 0,0, 1,5, 'h7F, 3));
        tbl.push_back(mk(1,0, 0,0, 1,7, 0,0, 1,6, 'hFF, 3));
        // same-cycle block+wake, halt, wake/block to halted, halt beats block
        tbl.push_back(mk(1,0, 1,3, 1,3, 0,0, 1,7, 'hF7, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 1,6, 1,0, 'hB7, 3));
        tbl.push_back(mk(1,0, 0,0, 1,6, 0,0, 1,1, 'hB7, 3));
        tbl.push_back(mk(1,0, 0,0, 1,3, 0,0, 1,2, 'hBF, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,3, 'hBF, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,4, 'hBF, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,5, 'hBF, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,7, 'hBF, 3));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,0, 'hBF, 3));
        tbl.push_back(mk(1,0, 1,6, 0,0, 0,0, 1,1, 'hBF, 3));
        tbl.push_back(mk(1,0, 1,7, 0,0, 1,7, 1,2, 'h3F, 3));
        tbl.push_back(mk(1,0, 0,0, 1,7, 0,0, 1,3, 'h3F, 3));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // stall holding thread 4, then block it mid-stall (threads 6,7 halted)
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,4, 'h3F, 3), 100);
        for (int i = 0; i < 3; i++) apply(mk(1,1, 0,0, 0,0, 0,0, 1,4, 'h3F, 3), 101 + i);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,5, 'h3F, 3), 104);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,0, 'h3F, 3), 105);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,1, 'h3F, 3), 106);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,2, 'h3F, 3), 107);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,3, 'h3F, 3), 108);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,4, 'h3F, 3), 109);
        apply(mk(1,1, 1,4, 0,0, 0,0, 0,4, 'h2F, 4), 110);
        apply(mk(1,1, 0,0, 0,0, 0,0, 0,4, 'h2F, 5), 111);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,5, 'h2F, 5), 112);

        // mid-run reset with pending events, then stall while invalid
        apply(mk(1,0, 1,0, 0,0, 0,0, 1,1, 'h2E, 5), 200);
        apply(mk(1,0, 1,1, 0,0, 0,0, 1,2, 'h2C, 5), 201);
        apply(mk(0,0, 1,3, 1,0, 1,2, 0,0, 'hFF, 0), 202);
        apply(mk(1,1, 0,0, 0,0, 0,0, 0,0, 'hFF, 1), 203);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,0, 'hFF, 1), 204);
        apply(mk(1,0, 0,0, 0,0, 0,0, 1,1, 'hFF, 1), 205);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
